key_onehot_latch: RTL and testbench
===================================

# key_onehot_latch

Upstream front end for the 8-to-3 key encoder: samples eight raw push-button lines, synchronises and debounces them, and presents a registered, held one-hot key vector on d0..d7 that feeds the encoder inputs directly. It emits a one-cycle `strobe` per accepted key press. It rejects chords (two or more keys down) with a one-cycle `err` pulse, so the encoder downstream never sees more than one hot input.

## Interface
- DEB_CYCLES, 4: consecutive stable cycles required to accept a new synchronised key vector. Legal range 1..65535.
- REPEAT_CYCLES, 16: autorepeat period in cycles. Used only with KEY_AUTOREPEAT_EN. Legal range 1..65535.
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- k0..k7  input  1 each  raw asynchronous key lines, 1 = pressed
- d0..d7  output  1 each  registered one-hot code of last accepted key; all 0 until first accept
- strobe  output  1  one-cycle pulse when d0..d7 are (re)loaded
- err  output  1  one-cycle pulse when a chord is debounced in IDLE

## Operation
- Synchroniser: 2-flop chain per key. Synchronised vector is `s[7:0]`.
- Debounce:
  - Candidate register `cand[7:0]` and 16-bit counter `cnt`.
  - If s != cand: cand <= s and cnt <= 0.
  - Else, if cnt < DEB_CYCLES-1: cnt increments.
  - Else: debounced vector `db` <= cand, and cnt holds (saturates).
- FSM, states IDLE and HELD:
  - IDLE, db == 0: stay.
  - IDLE, db has exactly one bit set: d0..d7 <= db, strobe = 1 for one cycle, go to HELD.
  - IDLE, db has two or more bits set: err = 1 for one cycle, d0..d7 unchanged, go to HELD.
  - HELD, db == 0: go to IDLE.
  - HELD, db nonzero: stay. Any change of db, including a different single key, is ignored until full release.
- d0..d7 are held between accepts. They never hold more than one set bit.
- strobe and err are never asserted in the same cycle.
- rst mid-operation: at the next edge all flops clear. This includes sync chain, cand, cnt, db, FSM (IDLE), d0..d7 (0), strobe (0), err (0) and the repeat counter. A key still held after reset is re-accepted through the full debounce path.

## Timing
- Reset values: d0..d7 = 0, strobe = 0, err = 0, state IDLE, db = 0.
- Edge 0 is the first edge sampling a steady new key level.
  - s is valid after edge 1.
  - cand loads at edge 2.
  - db updates at edge DEB_CYCLES+2.
  - strobe (or err) is high in the cycle after edge DEB_CYCLES+3, for exactly one cycle. With default DEB_CYCLES = 4 this is after edge 7.
  - d0..d7 change on the same edge that raises strobe.
- Release: db clears DEB_CYCLES+2 edges after the release is first sampled. The FSM returns to IDLE on the following edge. The earliest next accept is DEB_CYCLES+3 edges after a new press is first sampled.
- Glitch shorter than DEB_CYCLES cycles on s: the counter restarts, db is unchanged, and there is no strobe.
- DEB_CYCLES = 1: db loads on the edge after cand with no additional wait.

## Configuration
- KEY_AUTOREPEAT_EN:
  - Defined: a 16-bit repeat counter clears on entry to HELD from a single-key accept.
  - While in HELD with that key still the sole db bit, the counter increments each cycle.
  - On reaching REPEAT_CYCLES-1, strobe pulses for one cycle, d0..d7 reload the same value, and the counter clears.
  - First repeat strobe comes REPEAT_CYCLES cycles after the initial strobe.
  - No repeat after a chord (err) entry, or if db changes while HELD.
- Undefined: no repeat logic. Exactly one strobe per press-release cycle.

## Test plan
- Reset, then k3 = 1 held steady from edge 0 with DEB_CYCLES = 4 -> strobe high only after edge 7; d3 = 1, others 0; err = 0.
- k5 bounces 1/0/1 with 2-cycle gaps, then stays high -> single strobe DEB_CYCLES+3 edges after last transition sampled; d5 = 1.
- k1 and k6 pressed together -> one err pulse, no strobe, d0..d7 keep previous value; after release then k2 press -> strobe, d2 = 1.
- k4 accepted, then k7 also pressed while k4 held -> no strobe, no err, d4 stays 1 until full release and a new press.
- rst asserted one cycle while in HELD with k0 still pressed -> outputs 0 next edge; strobe again at edge DEB_CYCLES+3 counted from the first edge after rst deasserts.
- With KEY_AUTOREPEAT_EN, REPEAT_CYCLES = 16, k6 held 60 cycles past first strobe -> repeat strobes at +16, +32 and +48 cycles; d6 = 1 throughout; without macro -> exactly one strobe.

Source files
------------

// File: rtl/key_onehot_latch.sv
// Key front end: 2-flop synchroniser, debounce filter and IDLE/HELD FSM driving a held one-hot d0..d7.
// Build option: define KEY_AUTOREPEAT_EN to enable autorepeat strobes while a single key stays held.
module key_onehot_latch #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic k0,
  input  logic k1,
  input  logic k2,
  input  logic k3,
  input  logic k4,
  input  logic k5,
  input  logic k6,
  input  logic k7,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7,
  output logic strobe,
  output logic err,
  output logic dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 65535 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_bad_params
    $error("key_onehot_latch: DEB_CYCLES/REPEAT_CYCLES outside 1..65535");
  end

  logic [7:0]  k_raw;
  logic [7:0]  sync1_q;
  logic [7:0]  sync2_q;
  logic [7:0]  cand_q, cand_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  db_q, db_d;
  logic        db_onehot;
  state_e      state_q;
  logic [7:0]  d_q;
  logic        strobe_q;
  logic        err_q;

  assign k_raw = {k7, k6, k5, k4, k3, k2, k1, k0};

  // Raw lines are asynchronous; two flops per bit before anything looks at them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
    end else begin
      sync1_q <= k_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 16'd0;
    end else if (cnt_q < DEB_LAST) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      db_d = cand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= 8'd0;
      cnt_q  <= 16'd0;
      db_q   <= 8'd0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign db_onehot = (db_q != 8'd0) && ((db_q & (db_q - 8'd1)) == 8'd0);

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rep_q;
  logic        armed_q;
`endif

  // strobe and err are valid-only pulses (no ready): each is high for exactly
  // one cycle, never together, and d0..d7 are stable whenever strobe is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      d_q      <= 8'd0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_q    <= 16'd0;
      armed_q  <= 1'b0;
`endif
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (db_q != 8'd0) begin
            state_q <= ST_HELD;
            if (db_onehot) begin
              d_q      <= db_q;
              strobe_q <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              rep_q    <= 16'd0;
              armed_q  <= 1'b1;
`endif
            end else begin
              err_q <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              armed_q <= 1'b0;
`endif
            end
          end
        end
        ST_HELD: begin
          if (db_q == 8'd0) begin
            state_q <= ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
            armed_q <= 1'b0;
          end else if (armed_q && (db_q == d_q)) begin
            if (rep_q == REP_LAST) begin
              d_q      <= db_q;
              strobe_q <= 1'b1;
              rep_q    <= 16'd0;
            end else begin
              rep_q <= rep_q + 16'd1;
            end
          end else begin
            // Any change while held disarms repeat until the next full release.
            armed_q <= 1'b0;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {d7, d6, d5, d4, d3, d2, d1, d0} = d_q;
  assign strobe      = strobe_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_onehot_latch.sv
// Bench for key_onehot_latch: directed key scenarios plus random key traffic, pulses scored against a window-based model.
module tb_key_onehot_latch;

  localparam int DEB = 4;
  localparam int REP = 16;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_vec = 8'd0;
  wire  [7:0] d_out;
  wire        strobe;
  wire        err;
  wire        dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  key_onehot_latch #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst),
    .k0(key_vec[0]), .k1(key_vec[1]), .k2(key_vec[2]), .k3(key_vec[3]),
    .k4(key_vec[4]), .k5(key_vec[5]), .k6(key_vec[6]), .k7(key_vec[7]),
    .d0(d_out[0]), .d1(d_out[1]), .d2(d_out[2]), .d3(d_out[3]),
    .d4(d_out[4]), .d5(d_out[5]), .d6(d_out[6]), .d7(d_out[7]),
    .strobe(strobe), .err(err), .dbg_state_o(dbg_state)
  );

  // scoreboard: {edge number, err, strobe, d}
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: synchronised samples, debounce window, press/hold bookkeeping
  logic [7:0] p1 = 8'd0, p2 = 8'd0;
  logic [7:0] win[$];
  logic [7:0] db_m = 8'd0;
  logic [7:0] d_m  = 8'd0;
  bit         held_m  = 1'b0;
  bit         armed_m = 1'b0;
  int         rep_m   = 0;

  function automatic logic [31:0] pack(input int c, input logic e, input logic s, input logic [7:0] d);
    logic [31:0] w;
    w = {c[21:0], e, s, d};
    return w;
  endfunction

  // Applies the rules for one rising edge; a pulse predicted for that edge is queued.
  task automatic model_step();
    logic [7:0] s_seen;
    bit same;
    if (rst) begin
      p1 = 8'd0; p2 = 8'd0; win.delete();
      db_m = 8'd0; d_m = 8'd0; held_m = 1'b0; armed_m = 1'b0; rep_m = 0;
      return;
    end
    if (!held_m) begin
      if (db_m != 8'd0) begin
        held_m = 1'b1;
        if ($countones(db_m) == 1) begin
          d_m = db_m;
          exp_q.push_back(pack(cyc, 1'b0, 1'b1, d_m));
          armed_m = 1'b1;
          rep_m = 0;
        end else begin
          exp_q.push_back(pack(cyc, 1'b1, 1'b0, d_m));
          armed_m = 1'b0;
        end
      end
    end else if (db_m == 8'd0) begin
      held_m = 1'b0;
      armed_m = 1'b0;
    end else if (AUTO && armed_m && db_m == d_m) begin
      if (rep_m == REP - 1) begin
        exp_q.push_back(pack(cyc, 1'b0, 1'b1, d_m));
        rep_m = 0;
      end else begin
        rep_m++;
      end
    end else begin
      armed_m = 1'b0;
    end
    // a synchronised value is accepted once it has been seen DEB+1 edges in a row
    s_seen = p2;
    p2 = p1;
    p1 = key_vec;
    win.push_back(s_seen);
    if (win.size() > DEB + 1) void'(win.pop_front());
    if (win.size() == DEB + 1) begin
      same = 1'b1;
      foreach (win[i]) if (win[i] != s_seen) same = 1'b0;
      if (same) db_m = s_seen;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    key_vec = v;
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (edge %0d)", name, got, want, cyc);
    end
  endtask

  // monitor: pops one expectation per pulse and flags pulses that never came
  always @(negedge clk) begin
    logic [31:0] got;
    logic [31:0] want;
    if (strobe && err) begin
      checks++;
      errors++;
      $display("FAIL both_pulses strobe=1 err=1 required one at most (edge %0d)", cyc);
    end
    if (strobe || err) begin
      checks++;
      got = pack(cyc, err, strobe, d_out);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got=%08h required no pulse (edge %0d)", got, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL pulse got=%08h required=%08h (edge %0d)", got, want, cyc);
        end
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][31:10]) <= cyc) begin
      checks++;
      errors++;
      want = exp_q.pop_front();
      $display("FAIL missed_pulse got=none required=%08h (edge %0d)", want, cyc);
    end
  end

  initial begin
    logic [7:0] v;
    int a, b, r;
    rst = 1'b1;
    key_vec = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_state", {20'd0, d_out, strobe, err, dbg_state}, 32'd0);

    // single key k3
    hold(8'h08, 12);
    chk("k3_d", {24'd0, d_out}, 32'h08);
    hold(8'h00, 12);

    // k5 bouncing before settling
    hold(8'h20, 2); hold(8'h00, 2); hold(8'h20, 2); hold(8'h00, 2);
    hold(8'h20, 14);
    chk("k5_d", {24'd0, d_out}, 32'h20);
    hold(8'h00, 12);

    // chord k1+k6 leaves d untouched, then k2
    hold(8'h42, 12);
    chk("chord_d_kept", {24'd0, d_out}, 32'h20);
    hold(8'h00, 12);
    hold(8'h04, 12);
    chk("k2_d", {24'd0, d_out}, 32'h04);
    hold(8'h00, 12);

    // k4 held, k7 added, then k7 alone: ignored until full release
    hold(8'h10, 12);
    hold(8'h90, 20);
    chk("k4_k7_d", {24'd0, d_out}, 32'h10);
    hold(8'h80, 10);
    chk("k7_while_held_d", {24'd0, d_out}, 32'h10);
    hold(8'h00, 12);
    hold(8'h80, 12);
    chk("k7_d", {24'd0, d_out}, 32'h80);
    hold(8'h00, 12);

    // reset while k0 held
    hold(8'h01, 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_state", {20'd0, d_out, strobe, err, dbg_state}, 32'd0);
    hold(8'h01, 14);
    chk("k0_after_reset_d", {24'd0, d_out}, 32'h01);
    hold(8'h00, 12);

    // long hold of k6 (repeat strobes only in the autorepeat build)
    hold(8'h40, DEB + 3 + 62);
    chk("k6_long_d", {24'd0, d_out}, 32'h40);
    hold(8'h00, 12);

    // random traffic with occasional resets
    for (int seg = 0; seg < 90; seg++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) v = 8'h00;
      else if (r <= 7) v = 8'd1 << $urandom_range(0, 7);
      else if (r == 8) begin
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        v = (8'd1 << a) | (8'd1 << b);
      end else v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      hold(v, $urandom_range(1, 14));
    end

    hold(8'h00, 3 * DEB + 12);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_d_model", {24'd0, d_out}, {24'd0, d_m});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
